// File: rtl/power3_pkg.sv
// power3_pkg: shared definitions for the power3 scheduler.
//   OP_W    - operand / result width (8 bits, all arithmetic wraps mod 256)
//   state_e - scheduler FSM states
package power3_pkg;

   localparam int OP_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head output.
// Ports:
//   i_clk, i_arstn - clock, asynchronous active-low reset (empties the FIFO)
//   push, din      - write request and data (ignored while full)
//   pop            - remove head (ignored while empty)
//   full, empty    - occupancy flags
//   head           - oldest entry, valid while empty=0
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_arstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so equal indices can mean full or empty.
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage array; written only on an accepted push, no reset needed.
   always_ff @(posedge i_clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

   // Read/write pointers, wrapping naturally modulo 2*DEPTH.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

endmodule

// File: rtl/power3_sched.sv
// power3_sched: queues operands and feeds them one at a time to an external
// power3 engine, returning x^3 mod 256 together with the operand.
// Ports:
//   i_clk, i_arstn          - clock, asynchronous active-low reset
//   i_x, i_xValid, o_xReady - operand input handshake (o_xReady = FIFO not full)
//   o_start, o_engX         - one-cycle launch pulse and operand to the engine
//   i_engPower, i_engFinished - engine result and completion flag
//   o_res, o_resX, o_resValid, i_resReady - result output handshake
module power3_sched
   import power3_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_arstn,
   input  logic [OP_W-1:0] i_x,
   input  logic            i_xValid,
   output logic            o_xReady,
   output logic            o_start,
   output logic [OP_W-1:0] o_engX,
   input  logic [OP_W-1:0] i_engPower,
   input  logic            i_engFinished,
   output logic [OP_W-1:0] o_res,
   output logic [OP_W-1:0] o_resX,
   output logic            o_resValid,
   input  logic            i_resReady
);

   state_e          state_r;
   state_e          next_state_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic [OP_W-1:0] fifo_head_s;
   logic            pop_s;
   logic            capture_s;
   logic            first_run_r;
   logic [OP_W-1:0] pending_r;
   logic [OP_W-1:0] res_r;
   logic [OP_W-1:0] res_x_r;
   logic            start_r;
   logic            res_valid_r;
   logic [OP_W-1:0] eng_x_r;

   sync_fifo #(
      .WIDTH (OP_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_arstn (i_arstn),
      .push    (i_xValid),
      .din     (i_x),
      .pop     (pop_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .head    (fifo_head_s)
   );

   assign o_xReady = ~fifo_full_s;
   // The FSM only reaches LAUNCH with a non-empty FIFO, so this never pops empty.
   assign pop_s    = (state_r == ST_LAUNCH);
   // The engine's finished flag may still be high from the previous job during
   // the first RUN cycle, so it is only trusted from the second cycle on.
   assign capture_s = (state_r == ST_RUN) && !first_run_r && i_engFinished;

   assign o_start    = start_r;
   assign o_engX     = eng_x_r;
   assign o_res      = res_r;
   assign o_resX     = res_x_r;
   assign o_resValid = res_valid_r;

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               next_state_s = ST_LAUNCH;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            next_state_s = ST_RUN;
         end
         ST_RUN: begin
            if (capture_s) begin
               next_state_s = ST_HOLD;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (i_resReady) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_HOLD;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register plus outputs registered from the next state, so o_start
   // and o_resValid are high exactly while in LAUNCH and HOLD respectively.
   // The FIFO head is stable from IDLE into LAUNCH (no pop before LAUNCH).
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state_r     <= ST_IDLE;
         start_r     <= 1'b0;
         res_valid_r <= 1'b0;
         eng_x_r     <= {OP_W{1'b0}};
         first_run_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         start_r     <= (next_state_s == ST_LAUNCH);
         res_valid_r <= (next_state_s == ST_HOLD);
         first_run_r <= (state_r == ST_LAUNCH);
         if (next_state_s == ST_LAUNCH) begin
            eng_x_r <= fifo_head_s;
         end else begin
            eng_x_r <= {OP_W{1'b0}};
         end
      end
   end

   // Pending operand and captured result registers.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         pending_r <= {OP_W{1'b0}};
         res_r     <= {OP_W{1'b0}};
         res_x_r   <= {OP_W{1'b0}};
      end else begin
         if (state_r == ST_LAUNCH) begin
            pending_r <= fifo_head_s;
         end else begin
            pending_r <= pending_r;
         end
         if (capture_s) begin
            res_r   <= i_engPower;
            res_x_r <= pending_r;
         end else begin
            res_r   <= res_r;
            res_x_r <= res_x_r;
         end
      end
   end

endmodule

// File: doc/power3_sched.md
POWER3_SCHED -- requirements
Module: power3_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning input FIFO entries (power of two, >= 2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_arstn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_x  input  8  operand offered upstream.
REQ-005 SHALL have port i_xValid  input  1  i_x valid.
REQ-006 SHALL have port o_xReady  output  1  FIFO can accept (not full).
REQ-007 SHALL have port o_start  output  1  one-cycle start pulse to the power3 engine.
REQ-008 SHALL have port o_engX  output  8  operand to the engine, meaningful while o_start=1.
REQ-009 SHALL have port i_engPower  input  8  engine result.
REQ-010 SHALL have port i_engFinished  input  1  engine finished flag.
REQ-011 SHALL have port o_res  output  8  x^3 mod 256.
REQ-012 SHALL have port o_resX  output  8  operand that produced o_res.
REQ-013 SHALL have port o_resValid  output  1  result valid.
REQ-014 SHALL have port i_resReady  input  1  downstream accepts result.

Function
REQ-015 SHALL accept i_x into the FIFO on any cycle with i_xValid=1 and o_xReady=1; o_xReady SHALL be combinational on FIFO occupancy only (not on i_xValid).
REQ-016 SHALL run FSM states IDLE, LAUNCH, RUN, HOLD.
REQ-017 IDLE: SHALL go to LAUNCH when the FIFO is non-empty, else stay.
REQ-018 LAUNCH: SHALL assert o_start=1 with o_engX = FIFO head for exactly one cycle, pop the head, latch it as the pending operand, go to RUN.
REQ-019 RUN: SHALL ignore i_engFinished on the first RUN cycle (stale flag guard); from the second RUN cycle, i_engFinished=1 SHALL load o_res<=i_engPower and o_resX<=pending operand, and go to HOLD.
REQ-020 HOLD: SHALL drive o_resValid=1 holding o_res/o_resX stable; i_resReady=1 SHALL go to IDLE.
REQ-021 o_resValid SHALL be 1 only in HOLD; o_start SHALL be 1 only in LAUNCH.
REQ-022 With the engine's 3-cycle iteration, LAUNCH at cycle T SHALL give o_resValid=1 at T+4.
REQ-023 Simultaneous push and pop in LAUNCH SHALL both take effect; occupancy unchanged.
REQ-024 Push while full SHALL be impossible (o_xReady=0); pop occurs only in LAUNCH, never when empty.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH with an extra bit distinguishing full from empty.
REQ-026 Results SHALL emerge in push order; no result SHALL be dropped or duplicated.
REQ-027 All arithmetic SHALL be 8-bit; the block performs no arithmetic on data, passing engine truncation through unchanged.

Reset
REQ-028 i_arstn=0 SHALL immediately set FSM=IDLE, FIFO empty, o_start=0, o_resValid=0, o_res=0, o_resX=0, o_engX=0.
REQ-029 Reset mid-RUN SHALL abandon the job; post-reset i_engFinished SHALL be ignored until a new LAUNCH.
REQ-030 o_xReady SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Shared package power3_pkg SHALL hold the FSM state enum and the operand width constant (8).
REQ-032 FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head).
REQ-033 Top SHALL instantiate only sync_fifo; the power3 engine is connected externally by the integrator.

Verification (bench instantiates power3 engine alongside)
REQ-034 Push x=3, i_resReady=1 -> o_res=27, o_resX=3, o_resValid at LAUNCH+4.
REQ-035 Push 7, 0, 1, 255 back-to-back -> results 87, 0, 1, 255 in order, one each.
REQ-036 i_resReady=0, push until o_xReady=0, DEPTH=4 -> exactly 5 accepted (1 held, 4 queued); release ready -> 5 results in order.
REQ-037 Push in the LAUNCH cycle with FIFO at DEPTH-1 -> push accepted, occupancy unchanged.
REQ-038 Assert i_arstn=0 during RUN -> all outputs 0 asynchronously, no o_resValid until next push completes.
REQ-039 Hold i_engFinished=1 at LAUNCH (stale) -> no capture before second RUN cycle; result still correct.
